// File: rtl/mysum_pipe.sv
// mysum_pipe: pipelined signed summer.
//
// Sums in_terms signed inputs through a binary adder tree, then wraps or
// saturates the full-precision sum to out_bits and registers it.
// PIPE_ALL=1 registers every tree level; PIPE_ALL=0 keeps the tree
// combinational and registers only the output.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        clock enable; low holds every pipeline register
//   in_valid  qualifies the in vector
//   in        in_terms signed terms of in_bits each
//   out_valid out/ovf valid this cycle
//   out       registered signed sum, out_bits wide
//   ovf       full-precision sum did not fit in out_bits (valid slots only)

// One tree node: a W-bit signed add, registered or combinational.
// Node width already covers the full-precision sum, so the add cannot
// overflow at any level.
module mysum_node #(
    parameter int W   = 8,
    parameter bit REG = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    if (REG) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  y <= '0;
            else if (en) y <= a + b;
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = clk ^ rst_n ^ en;
        assign y = a + b;
    end

endmodule

module mysum_pipe #(
    parameter int in_bits  = 8,
    parameter int in_terms = 4,
    parameter int out_bits = 10,
    parameter bit PIPE_ALL = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic signed [in_bits-1:0]  in [in_terms-1:0],
    output logic                       out_valid,
    output logic signed [out_bits-1:0] out,
    output logic                       ovf
);

    localparam int L      = (in_terms > 1) ? $clog2(in_terms) : 0;
    localparam int W      = in_bits + L;
    localparam int STAGES = PIPE_ALL ? L : 0;
    localparam int VW     = STAGES + 1;

    // lvl[k][i]: node i at tree level k, all carried at full width W.
    logic signed [W-1:0] lvl [0:L][0:in_terms-1];

    for (genvar i = 0; i < in_terms; i++) begin : g_lvl0
        assign lvl[0][i] = W'(in[i]);   // sign-extend into full width
    end

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NK = (in_terms + (1 << k) - 1) >> k;  // live terms at level k
        for (genvar i = 0; i < in_terms; i++) begin : g_node
            if (2*i + 1 < NK) begin : g_pair
                mysum_node #(.W(W), .REG(PIPE_ALL)) u_node (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (en),
                    .a     (lvl[k][2*i]),
                    .b     (lvl[k][2*i+1]),
                    .y     (lvl[k+1][i])
                );
            end else if (2*i < NK) begin : g_pass
                // Odd leftover still goes through a node so it stays
                // aligned with its siblings when levels are registered.
                mysum_node #(.W(W), .REG(PIPE_ALL)) u_node (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (en),
                    .a     (lvl[k][2*i]),
                    .b     ('0),
                    .y     (lvl[k+1][i])
                );
            end else begin : g_none
                assign lvl[k+1][i] = '0;
            end
        end
    end

    logic signed [W-1:0]        s;
    logic signed [out_bits-1:0] res;
    logic                       res_ovf;

    assign s = lvl[L][0];

    if (out_bits >= W) begin : g_ext
        assign res     = out_bits'(s);
        assign res_ovf = 1'b0;
    end else begin : g_narrow
        // S fits in out_bits iff all bits from the out MSB upward agree.
        logic [W-out_bits:0] hi;
        logic                fits;
        assign hi   = s[W-1:out_bits-1];
        assign fits = (&hi) | ~(|hi);
        assign res_ovf = ~fits;
        if (SATURATE) begin : g_sat
            localparam logic signed [out_bits-1:0] OMAX = {out_bits{1'b1}} >> 1;
            assign res = fits ? s[out_bits-1:0] : (s[W-1] ? ~OMAX : OMAX);
        end else begin : g_wrap
            assign res = s[out_bits-1:0];
        end
    end

    // Valid tag: one bit per register stage, last bit is the output slot.
    logic [STAGES:0] vld_pipe;
    logic            ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            out      <= '0;
            ovf_r    <= 1'b0;
        end else if (en) begin
            vld_pipe <= VW'({vld_pipe, in_valid});
            out      <= res;
            ovf_r    <= res_ovf;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign ovf       = ovf_r & out_valid;  // data slots capture garbage when invalid

endmodule

// File: tb/tb_mysum_pipe.sv
// Bench for mysum_pipe: seven parameter variants share one stimulus stream.
// A per-variant arithmetic model schedules each valid sample's expected
// result at (en-high edge index + latency - 1); the compare process checks
// every DUT each cycle, plus literal hand-computed values for key samples.
module tb_mysum_pipe;

    localparam int ND = 7;
    //                            A   B   C   D   E   F   G
    localparam int IB  [ND] = '{  8,  4,  8,  8,  8,  8,  8};
    localparam int NT  [ND] = '{  4,  5,  4,  4,  4,  1,  1};
    localparam int OB  [ND] = '{ 10, 10,  8,  8, 10,  4,  4};
    localparam int SAT [ND] = '{  0,  0,  0,  1,  0,  0,  1};
    localparam int LAT [ND] = '{  3,  4,  3,  3,  1,  1,  1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic in_valid = 1'b0;
    int   stim [5];

    always #5 clk = ~clk;

    logic signed [7:0] in0 [3:0];
    logic signed [3:0] in1 [4:0];
    logic signed [7:0] in2 [3:0];
    logic signed [7:0] in3 [3:0];
    logic signed [7:0] in4 [3:0];
    logic signed [7:0] in5 [0:0];
    logic signed [7:0] in6 [0:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in0[i] = 8'(stim[i]);
            in2[i] = 8'(stim[i]);
            in3[i] = 8'(stim[i]);
            in4[i] = 8'(stim[i]);
        end
        for (int i = 0; i < 5; i++) in1[i] = 4'(stim[i]);
        in5[0] = 8'(stim[0]);
        in6[0] = 8'(stim[0]);
    end

    logic v0, v1, v2, v3, v4, v5, v6;
    logic f0, f1, f2, f3, f4, f5, f6;
    logic signed [9:0] o0, o1, o4;
    logic signed [7:0] o2, o3;
    logic signed [3:0] o5, o6;

    mysum_pipe #(.in_bits(8), .in_terms(4), .out_bits(10), .PIPE_ALL(1), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in0),
        .out_valid(v0), .out(o0), .ovf(f0));
    mysum_pipe #(.in_bits(4), .in_terms(5), .out_bits(10), .PIPE_ALL(1), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in1),
        .out_valid(v1), .out(o1), .ovf(f1));
    mysum_pipe #(.in_bits(8), .in_terms(4), .out_bits(8), .PIPE_ALL(1), .SATURATE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in2),
        .out_valid(v2), .out(o2), .ovf(f2));
    mysum_pipe #(.in_bits(8), .in_terms(4), .out_bits(8), .PIPE_ALL(1), .SATURATE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in3),
        .out_valid(v3), .out(o3), .ovf(f3));
    mysum_pipe #(.in_bits(8), .in_terms(4), .out_bits(10), .PIPE_ALL(0), .SATURATE(0)) u4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in4),
        .out_valid(v4), .out(o4), .ovf(f4));
    mysum_pipe #(.in_bits(8), .in_terms(1), .out_bits(4), .PIPE_ALL(1), .SATURATE(0)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in5),
        .out_valid(v5), .out(o5), .ovf(f5));
    mysum_pipe #(.in_bits(8), .in_terms(1), .out_bits(4), .PIPE_ALL(0), .SATURATE(1)) u6 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in6),
        .out_valid(v6), .out(o6), .ovf(f6));

    int got_v [ND];
    int got_o [ND];
    int got_f [ND];

    always_comb begin
        got_v[0] = int'(v0); got_o[0] = int'(o0); got_f[0] = int'(f0);
        got_v[1] = int'(v1); got_o[1] = int'(o1); got_f[1] = int'(f1);
        got_v[2] = int'(v2); got_o[2] = int'(o2); got_f[2] = int'(f2);
        got_v[3] = int'(v3); got_o[3] = int'(o3); got_f[3] = int'(f3);
        got_v[4] = int'(v4); got_o[4] = int'(o4); got_f[4] = int'(f4);
        got_v[5] = int'(v5); got_o[5] = int'(o5); got_f[5] = int'(f5);
        got_v[6] = int'(v6); got_o[6] = int'(o6); got_f[6] = int'(f6);
    end

    // Expected outputs, indexed by the en-high edge after which they show.
    bit ev  [ND][4096];
    int evv [ND][4096];
    bit evo [ND][4096];
    bit lon [ND][4096];
    int lvv [ND][4096];
    bit lvo [ND][4096];

    bit lit_on  [ND];
    int lit_val [ND];
    bit lit_ovf [ND];

    int en_cnt  = 0;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic int sext(input int x, input int b);
        int t;
        t = x <<< (32 - b);
        return t >>> (32 - b);
    endfunction

    function automatic void model(input int d, output int val, output bit o);
        int s, lo, hi;
        s = 0;
        for (int i = 0; i < NT[d]; i++) s += sext(stim[i], IB[d]);
        lo = -(1 <<< (OB[d] - 1));
        hi = (1 <<< (OB[d] - 1)) - 1;
        o = (s > hi) || (s < lo);
        if (!o)          val = s;
        else if (SAT[d] != 0) val = (s > hi) ? hi : lo;
        else             val = sext(s, OB[d]);
    endfunction

    task automatic chk(input string nm, input int d, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge%0d got %0d expected %0d", nm, d, en_cnt, got, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int v;
        bit o;
        int idx;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++)
                for (int k = 0; k < 16; k++) begin
                    ev[d][en_cnt+k]  = 1'b0;
                    lon[d][en_cnt+k] = 1'b0;
                end
        end else if (en) begin
            en_cnt++;
            if (in_valid) begin
                for (int d = 0; d < ND; d++) begin
                    model(d, v, o);
                    idx = en_cnt + LAT[d] - 1;
                    ev[d][idx]  = 1'b1;
                    evv[d][idx] = v;
                    evo[d][idx] = o;
                    lon[d][idx] = lit_on[d];
                    lvv[d][idx] = lit_val[d];
                    lvo[d][idx] = lit_ovf[d];
                end
            end
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                chk("rst_valid", d, got_v[d], 0);
                chk("rst_out",   d, got_o[d], 0);
                chk("rst_ovf",   d, got_f[d], 0);
            end else begin
                chk("valid", d, got_v[d], int'(ev[d][en_cnt]));
                if (ev[d][en_cnt]) begin
                    chk("sum", d, got_o[d], evv[d][en_cnt]);
                    chk("ovf", d, got_f[d], int'(evo[d][en_cnt]));
                    if (lon[d][en_cnt]) begin
                        chk("lit_sum", d, got_o[d], lvv[d][en_cnt]);
                        chk("lit_ovf", d, got_f[d], int'(lvo[d][en_cnt]));
                    end
                end else begin
                    chk("ovf_idle", d, got_f[d], 0);
                end
            end
        end
    end

    task automatic put(input int a, input int b, input int c, input int e, input int f, input bit v);
        stim[0] = a; stim[1] = b; stim[2] = c; stim[3] = e; stim[4] = f;
        in_valid = v;
        for (int d = 0; d < ND; d++) lit_on[d] = 1'b0;
    endtask

    task automatic lit(input int d, input int v, input bit o);
        lit_on[d]  = 1'b1;
        lit_val[d] = v;
        lit_ovf[d] = o;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        put(0, 0, 0, 0, 0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        en    = 1'b1;

        // Basic pipelined sum
        put(1, 2, 3, -4, 0, 1'b1); lit(0, 2, 1'b0); lit(1, 2, 1'b0); lit(4, 2, 1'b0); tick();
        put(0, 0, 0, 0, 0, 1'b0); repeat (6) tick();

        // Streaming, odd term count
        put(7, 7, 7, 7, 7, 1'b1);      lit(1, 35, 1'b0);  lit(0, 28, 1'b0);  tick();
        put(-8, -8, -8, -8, -8, 1'b1); lit(1, -40, 1'b0); lit(0, -32, 1'b0); tick();

        // Wrap vs saturate
        put(100, 100, 100, 100, 0, 1'b1);
        lit(2, -112, 1'b1); lit(3, 127, 1'b1); lit(0, 400, 1'b0); lit(6, 7, 1'b1); tick();
        put(-128, -128, -128, -128, 0, 1'b1); lit(2, 0, 1'b1); lit(3, -128, 1'b1); tick();
        put(50, 50, 20, 0, 0, 1'b1);          lit(2, 120, 1'b0); lit(3, 120, 1'b0); tick();

        // Single term
        put(-3, 0, 0, 0, 0, 1'b1);   lit(5, -3, 1'b0); lit(6, -3, 1'b0); tick();
        put(-100, 0, 0, 0, 0, 1'b1); lit(6, -8, 1'b1); lit(5, -4, 1'b1); tick();
        put(0, 0, 0, 0, 0, 1'b0); repeat (6) tick();

        // Stall with junk inputs while en is low
        put(1, 1, 1, 1, 0, 1'b1); lit(0, 4, 1'b0); lit(3, 4, 1'b0); lit(4, 4, 1'b0); tick();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(9 + k, -9, 5, 3 - k, 1, (k % 2) == 0);
            tick();
        end
        en = 1'b1;
        put(0, 0, 0, 0, 0, 1'b0); repeat (6) tick();

        // Reset mid-flight
        put(3, 1, 4, 1, 5, 1'b1);    tick();
        put(2, 7, 1, 8, 2, 1'b1);    tick();
        put(-5, -6, 7, 0, 1, 1'b1);  tick();
        put(0, 0, 0, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();

        // First sample right after release
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        put(5, 5, 5, 5, 5, 1'b1); lit(0, 20, 1'b0); lit(1, 25, 1'b0); lit(6, 5, 1'b0); tick();
        put(0, 0, 0, 0, 0, 1'b0); repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
